// File: rtl/collision_pkg.sv
// Shared types and defaults for the collision detector and its event handler.
package collision_pkg;

  localparam int unsigned X_W_DEF = 11;
  localparam int unsigned Y_W_DEF = 10;

  typedef enum logic [1:0] {
    ARMED,
    REPORT,
    HOLDOFF
  } coll_state_t;

  // A holdoff of 0 frames still needs one counter bit to exist.
  function automatic int unsigned holdoff_cnt_w(input int unsigned frames);
    int unsigned w;
    w = $clog2(frames + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_holdoff_counter.sv
// Frame-counted holdoff: loads a frame budget and decrements it once per start-of-frame.
module frame_holdoff_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_sof,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over a same-cycle SOF so that frame is not counted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_sof && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/collision_event_handler.sv
// Turns the per-pixel collision stream into at most one acknowledged hit event per frame,
// followed by a frame-counted invulnerability window.
module collision_event_handler
  import collision_pkg::*;
#(
  parameter int unsigned X_W            = X_W_DEF,
  parameter int unsigned Y_W            = Y_W_DEF,
  parameter int unsigned HOLDOFF_FRAMES = 30,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_startOfFrame,
  input  logic             i_collision,
  input  logic [X_W-1:0]   i_pixelX,
  input  logic [Y_W-1:0]   i_pixelY,
  input  logic             i_event_ack,
  output logic             o_event_req,
  output logic [X_W-1:0]   o_hit_x,
  output logic [Y_W-1:0]   o_hit_y,
  output logic [CNT_W-1:0] o_hit_count,
  output logic             o_invulnerable
);

  localparam int unsigned       HCW      = holdoff_cnt_w(HOLDOFF_FRAMES);
  localparam logic [HCW-1:0]    HOLD_VAL = HCW'(HOLDOFF_FRAMES);

  coll_state_t      r_state;
  coll_state_t      w_state_next;
  logic [X_W-1:0]   r_px_d;
  logic [Y_W-1:0]   r_py_d;
  logic [X_W-1:0]   r_hit_x;
  logic [Y_W-1:0]   r_hit_y;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_event_req;
  logic             r_invulnerable;
  logic             w_capture;
  logic             w_load;
  logic             w_sof_dec;
  logic             w_zero;

  // The collision pulse lags the pixel counters by one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_px_d <= '0;
      r_py_d <= '0;
    end else begin
      r_px_d <= i_pixelX;
      r_py_d <= i_pixelY;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_sof_dec    = 1'b0;
    unique case (r_state)
      ARMED: begin
        if (i_collision) begin
          w_capture    = 1'b1;
          w_state_next = REPORT;
        end
      end
      REPORT: begin
        if (i_event_ack) begin
          w_load       = 1'b1;
          w_state_next = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // Re-arming takes the whole SOF cycle, so a coincident collision is dropped.
        if (i_startOfFrame) begin
          if (w_zero) begin
            w_state_next = ARMED;
          end else begin
            w_sof_dec = 1'b1;
          end
        end
      end
      default: w_state_next = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= ARMED;
      r_event_req    <= 1'b0;
      r_invulnerable <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_invulnerable <= (w_state_next != ARMED);
      if (w_capture) begin
        r_event_req <= 1'b1;
      end else if (w_load) begin
        r_event_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_x     <= '0;
      r_hit_y     <= '0;
      r_hit_count <= '0;
    end else if (w_capture) begin
      r_hit_x <= r_px_d;
      r_hit_y <= r_py_d;
      if (r_hit_count != '1) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  frame_holdoff_counter #(
    .CNT_W(HCW)
  ) u_holdoff (
    .clk       (clk),
    .resetN    (resetN),
    .i_load    (w_load),
    .i_load_val(HOLD_VAL),
    .i_sof     (w_sof_dec),
    .o_zero    (w_zero)
  );

  assign o_event_req    = r_event_req;
  assign o_hit_x        = r_hit_x;
  assign o_hit_y        = r_hit_y;
  assign o_hit_count    = r_hit_count;
  assign o_invulnerable = r_invulnerable;

endmodule

// File: tb/tb_collision_event_handler.sv
// Three handler configurations driven in lockstep, checked every cycle against an event-level model.
module tb_collision_event_handler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof, col, ack;
  logic [10:0] px;
  logic [9:0]  py;
  logic        cmp_en = 1'b0;

  logic        req_0, inv_0, req_2, inv_2, req_c, inv_c;
  logic [10:0] hx_0, hx_2, hx_c;
  logic [9:0]  hy_0, hy_2, hy_c;
  logic [7:0]  cnt_0, cnt_2;
  logic [1:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_event_handler #(.HOLDOFF_FRAMES(0)) u_d0 (
    .clk(clk), .resetN(resetN), .i_startOfFrame(sof), .i_collision(col), .i_pixelX(px),
    .i_pixelY(py), .i_event_ack(ack), .o_event_req(req_0), .o_hit_x(hx_0), .o_hit_y(hy_0),
    .o_hit_count(cnt_0), .o_invulnerable(inv_0)
  );

  collision_event_handler #(.HOLDOFF_FRAMES(2)) u_d2 (
    .clk(clk), .resetN(resetN), .i_startOfFrame(sof), .i_collision(col), .i_pixelX(px),
    .i_pixelY(py), .i_event_ack(ack), .o_event_req(req_2), .o_hit_x(hx_2), .o_hit_y(hy_2),
    .o_hit_count(cnt_2), .o_invulnerable(inv_2)
  );

  collision_event_handler #(.HOLDOFF_FRAMES(1), .CNT_W(2)) u_dc (
    .clk(clk), .resetN(resetN), .i_startOfFrame(sof), .i_collision(col), .i_pixelX(px),
    .i_pixelY(py), .i_event_ack(ack), .o_event_req(req_c), .o_hit_x(hx_c), .o_hit_y(hy_c),
    .o_hit_count(cnt_c), .o_invulnerable(inv_c)
  );

  // Event-level model: an outstanding event, or a number of frame starts still to wait
  // (-1 once the handler may take a new hit).
  typedef struct packed {
    bit pending;
    int wt;
    int hx;
    int hy;
    int cnt;
    int px;
    int py;
  } model_t;

  model_t m[3];

  function automatic int hold_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 1;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic model_t mreset();
    model_t r;
    r.pending = 1'b0; r.wt = -1; r.hx = 0; r.hy = 0; r.cnt = 0; r.px = 0; r.py = 0;
    return r;
  endfunction

  function automatic model_t mstep(input model_t o, input int hold, input int cmax,
                                   input bit s, input bit c, input bit a, input int x,
                                   input int y);
    model_t n;
    n = o;
    if (!o.pending && o.wt < 0) begin
      if (c) begin
        n.pending = 1'b1;
        n.hx = o.px;
        n.hy = o.py;
        n.cnt = (o.cnt < cmax) ? o.cnt + 1 : o.cnt;
      end
    end else if (o.pending) begin
      if (a) begin
        n.pending = 1'b0;
        n.wt = hold;
      end
    end else if (s) begin
      n.wt = o.wt - 1;
    end
    n.px = x;
    n.py = y;
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 3; i++) m[i] <= mreset();
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= mstep(m[i], hold_of(i), cmax_of(i), sof, col, ack, int'(px), int'(py));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic r, input logic [10:0] x, input logic [9:0] y,
                     input logic [7:0] c, input logic v);
    check($sformatf("d%0d event_req", i), 32'(r), 32'(m[i].pending));
    check($sformatf("d%0d hit_x", i), 32'(x), m[i].hx);
    check($sformatf("d%0d hit_y", i), 32'(y), m[i].hy);
    check($sformatf("d%0d hit_count", i), 32'(c), m[i].cnt);
    check($sformatf("d%0d invulnerable", i), 32'(v), 32'(m[i].pending || m[i].wt >= 0));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, req_0, hx_0, hy_0, cnt_0, inv_0);
      cmp(1, req_2, hx_2, hy_2, cnt_2, inv_2);
      cmp(2, req_c, hx_c, hy_c, {6'b0, cnt_c}, inv_c);
    end
  end

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic step(input bit s, input bit c, input bit a, input int x, input int y);
    sof = s; col = c; ack = a; px = 11'(x); py = 10'(y);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    sof = 0; col = 0; ack = 0;
    resetN = 1'b0;
    @(posedge clk);
    #2;
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    sof = 0; col = 0; ack = 0; px = '0; py = '0;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("reset event_req", 32'(req_2), 0);
    check("reset hit_x", 32'(hx_2), 0);
    check("reset hit_count", 32'(cnt_2), 0);
    check("reset invulnerable", 32'(inv_2), 0);
    resetN = 1'b1;

    // Single hit at (100,50), acknowledged three cycles after the collision.
    step(1, 0, 0, 100, 50);
    check("t1 req before hit", 32'(req_2), 0);
    step(0, 1, 0, 7, 7);
    check("t1 req rises", 32'(req_2), 1);
    check("t1 hit_x", 32'(hx_2), 100);
    check("t1 hit_y", 32'(hy_2), 50);
    check("t1 hit_count", 32'(cnt_2), 1);
    step(0, 0, 0, 8, 7);
    step(0, 0, 0, 9, 7);
    check("t1 req held", 32'(req_2), 1);
    step(0, 0, 1, 10, 7);
    check("t1 req falls", 32'(req_2), 0);
    check("t1 hit_x held", 32'(hx_2), 100);
    step(0, 0, 0, 0, 0);

    // Burst of collisions in one frame, zero holdoff.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 200, 60);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 201 + k, 60);
    check("t2 single event x", 32'(hx_0), 200);
    check("t2 single event y", 32'(hy_0), 60);
    check("t2 count", 32'(cnt_0), 1);
    step(0, 0, 1, 0, 0);
    check("t2 req cleared", 32'(req_0), 0);
    step(0, 1, 0, 0, 0);
    check("t2 same-frame hit ignored", 32'(cnt_0), 1);
    check("t2 still invulnerable", 32'(inv_0), 1);
    step(1, 0, 0, 300, 70);
    check("t2 rearm at sof", 32'(inv_0), 0);
    step(0, 1, 0, 0, 0);
    check("t2 next hit x", 32'(hx_0), 300);
    check("t2 next count", 32'(cnt_0), 2);
    step(0, 0, 1, 0, 0);

    // Two-frame holdoff with a collision every frame and immediate ack.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      step(1, (f == 3), 0, 0, 0);
      if (f == 3) begin
        check("t3 sof+collision dropped", 32'(req_2), 0);
        check("t3 rearmed", 32'(inv_2), 0);
      end
      step(0, 0, 0, 10 + f, 20 + f);
      step(0, 1, 0, 0, 0);
      check($sformatf("t3 frame %0d event", f), 32'(req_2), 32'((f == 0) || (f == 3)));
      check($sformatf("t3 frame %0d invulnerable", f), 32'(inv_2), 1);
      if (f == 3) check("t3 frame 3 hit_x", 32'(hx_2), 13);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    check("t3 total hits", 32'(cnt_2), 2);

    // Ack withheld for three frames of continuing collisions.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 400, 80);
    step(0, 1, 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      step(1, 1, 0, 500 + f, 90);
      step(0, 1, 0, 510 + f, 91);
      step(0, 0, 0, 0, 0);
    end
    check("t4 req held", 32'(req_0), 1);
    check("t4 hit_x held", 32'(hx_0), 400);
    check("t4 hit_y held", 32'(hy_0), 80);
    check("t4 count held", 32'(cnt_0), 1);
    step(1, 0, 1, 0, 0);
    check("t4 ack+sof req", 32'(req_0), 0);
    check("t4 ack+sof not counted", 32'(inv_0), 1);
    step(1, 0, 0, 0, 0);
    check("t4 rearm next sof", 32'(inv_0), 0);

    // Saturating 2-bit hit counter; each hit lands on a start-of-frame cycle.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, k, k);
      check($sformatf("t5 hit %0d count", k), 32'(cnt_c), (k + 1 > 3) ? 3 : k + 1);
      check($sformatf("t5 hit %0d req", k), 32'(req_c), 1);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check($sformatf("t5 hit %0d rearmed", k), 32'(inv_c), 0);
    end

    // Reset while an event is pending.
    step(0, 0, 0, 600, 100);
    step(0, 1, 0, 0, 0);
    check("t6 pending before reset", 32'(req_c), 1);
    sof = 0; col = 0; ack = 0;
    resetN = 1'b0;
    #1;
    check("t6 reset req", 32'(req_c), 0);
    check("t6 reset count", 32'(cnt_c), 0);
    check("t6 reset invulnerable", 32'(inv_c), 0);
    @(posedge clk);
    #2;
    resetN = 1'b1;
    step(0, 0, 0, 700, 110);
    step(0, 1, 0, 0, 0);
    check("t6 capture after reset req", 32'(req_c), 1);
    check("t6 capture after reset x", 32'(hx_c), 700);
    check("t6 capture after reset y", 32'(hy_c), 110);
    check("t6 capture after reset count", 32'(cnt_c), 1);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
